// File: rtl/mips_trace_buffer.sv
// Debug trace capture for mips_core: masked trigger on channel 0, post-trigger window,
// circular buffer read out oldest-first. Define TRACE_TIMESTAMP_EN to add per-entry cycle stamps (rd_ts).
module mips_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 3,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [DATA_W-1:0]        trig_value,
  output logic                     armed,
  output logic                     triggered,
  output logic                     done,
  output logic                     wrapped,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_last
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [15:0]              rd_ts
`endif
);

  localparam int SW = NUM_CH * DATA_W;
  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_ENTRY = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_inc, first_addr;
  logic [ADDR_W:0]   count, count_nxt, rd_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic              hit, we, enter_done, accept;
  logic [SW-1:0]     first_data;

  assign hit    = sample_valid &&
                  ((sample_data[DATA_W-1:0] & trig_mask) == (trig_value & trig_mask));
  assign we     = !arm && sample_valid && (state == ARMED || state == POST);
  assign accept = (state == DONE) && rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED:   if (we && hit) state_nxt = (POST_TRIG == 0) ? DONE : POST;
        POST:    if (sample_valid && post_cnt == ADDR_W'(1)) state_nxt = DONE;
        DONE:    if (accept && rd_last) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    armed = (state == ARMED) || (state == POST);
    done  = (state == DONE);
  end

  // The oldest entry is computed from post-write pointers; when the final sample lands
  // in that same slot (single-entry capture) it is bypassed straight onto rd_data.
  always_comb begin
    wr_ptr_nxt = wr_ptr + ADDR_W'(we);
    count_nxt  = (we && count != FULL) ? count + 1'b1 : count;
    first_addr = wr_ptr_nxt - count_nxt[ADDR_W-1:0];
    first_data = (we && wr_ptr == first_addr) ? sample_data : mem[first_addr];
    rd_ptr_inc = rd_ptr + 1'b1;
    enter_done = (state_nxt == DONE) && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else if (arm) begin
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      if (we && count == FULL) wrapped <= 1'b1;

      if (state == ARMED && we && hit) begin
        triggered <= 1'b1;
        post_cnt  <= POST_INIT;
      end else if (state == POST && sample_valid) begin
        post_cnt <= post_cnt - 1'b1;
      end

      if (enter_done) begin
        rd_ptr   <= first_addr;
        rd_data  <= first_data;
        rd_valid <= 1'b1;
        rd_last  <= (count_nxt == ONE_ENTRY);
        rd_cnt   <= ONE_ENTRY;
      end else if (accept) begin
        if (rd_last) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end else begin
          rd_ptr  <= rd_ptr_inc;
          rd_data <= mem[rd_ptr_inc];
          rd_cnt  <= rd_cnt + 1'b1;
          rd_last <= (rd_cnt + 1'b1 == count);
        end
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_mem [DEPTH];
  logic [15:0] ts_first;

  assign ts_first = (we && wr_ptr == first_addr) ? ts_cnt : ts_mem[first_addr];

  always_ff @(posedge clk) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) ts_mem[wr_ptr] <= ts_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset)                    rd_ts <= '0;
    else if (enter_done)           rd_ts <= ts_first;
    else if (accept && !rd_last)   rd_ts <= ts_mem[rd_ptr_inc];
  end
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (DEPTH=8, POST_TRIG=2) against a queue-based
// model: every stored sample is kept, readout expects the newest DEPTH of them.
module tb_mips_trace_buffer;
  localparam int DW = 32, NCH = 3, DEP = 8, AW = 3, PT = 2, CW = NCH * DW;

  logic clk = 1'b0;
  logic reset, arm, sample_valid, rd_ready;
  logic [CW-1:0] sample_data, rd_data;
  logic [DW-1:0] trig_mask, trig_value;
  logic armed, triggered, done, wrapped, rd_valid, rd_last;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  always #5 clk = ~clk;

  mips_trace_buffer #(.DATA_W(DW), .NUM_CH(NCH), .DEPTH(DEP), .ADDR_W(AW), .POST_TRIG(PT)) dut (
    .clk(clk), .reset(reset), .arm(arm), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_mask(trig_mask), .trig_value(trig_value), .armed(armed), .triggered(triggered),
    .done(done), .wrapped(wrapped), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  int checks = 0, fails = 0;

  // model: phase 0 idle, 1 waiting for trigger, 2 post window, 3 readout
  int phase = 0, post_left = 0;
  bit m_trig = 0, m_wrap = 0;
  logic [CW-1:0] stored[$];
  logic [CW-1:0] expq[$];

  function automatic logic [5:0] exp_flags();
    logic [5:0] f;
    f = {phase == 1 || phase == 2, m_trig, phase == 3, m_wrap, phase == 3,
         phase == 3 && expq.size() == 1};
    return f;
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      phase = 0; m_trig = 0; m_wrap = 0; stored.delete(); expq.delete();
    end else if (arm) begin
      phase = 1; m_trig = 0; m_wrap = 0; stored.delete(); expq.delete();
    end else if ((phase == 1 || phase == 2) && sample_valid) begin
      stored.push_back(sample_data);
      if (stored.size() > DEP) m_wrap = 1;
      if (phase == 1) begin
        if (((sample_data[DW-1:0] ^ trig_value) & trig_mask) == '0) begin
          m_trig = 1; post_left = PT; phase = 2;
        end
      end else begin
        post_left--;
      end
      if (phase == 2 && post_left == 0) begin
        phase = 3;
        expq.delete();
        for (int i = (stored.size() > DEP ? stored.size() - DEP : 0); i < stored.size(); i++)
          expq.push_back(stored[i]);
      end
    end else if (phase == 3 && rd_ready) begin
      void'(expq.pop_front());
      if (expq.size() == 0) phase = 0;
    end
  endfunction

  task automatic tick(input bit a, input bit sv, input logic [CW-1:0] d, input bit rr);
    arm = a; sample_valid = sv; sample_data = d; rd_ready = rr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input logic [DW-1:0] c0);
    logic [CW-1:0] s;
    s = {$urandom(), $urandom(), c0};
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b0; trig_mask = '1; trig_value = '0;
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    checks++;
    if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 000000", {armed, triggered, done, wrapped, rd_valid, rd_last});
    end
    checks++;
    if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(0, 1'($urandom % 2), mk(32'h0), 1'($urandom % 2));
      checks++;
      if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
        fails++; $display("FAIL idle_flags c=%0d: got %b want %b", c, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
      end
    end
  endtask

  task automatic test_wrap_capture();
    int n;
    logic [DW-1:0] e;
    trig_mask = '1; trig_value = 32'd40;
    tick(1, 0, '0, 0);
    for (int k = 0; k < 20; k++) begin
      tick(0, 1, mk(32'(4 * k)), 0);
      checks++;
      if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
        fails++; $display("FAIL wrap_flags k=%0d: got %b want %b", k, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
      end
      checks++;
      if ({triggered, done} !== {k >= 10, k >= 12}) begin
        fails++; $display("FAIL wrap_trig_done k=%0d: got %b%b want %b%b", k, triggered, done, k >= 10, k >= 12);
      end
    end
    checks++;
    if (wrapped !== 1'b1) begin fails++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
    n = 0;
    for (int c = 0; c < 40 && phase == 3; c++) begin
      e = 32'(20 + 4 * n);
      checks++;
      if (rd_data !== expq[0] || rd_data[DW-1:0] !== e || rd_last !== (n == 7)) begin
        fails++; $display("FAIL wrap_data n=%0d: got %h last=%b want ch0=%h last=%b", n, rd_data, rd_last, e, n == 7);
      end
      n++;
      tick(0, 0, '0, 1);
    end
    checks++;
    if (n != 8 || rd_valid !== 1'b0) begin fails++; $display("FAIL wrap_count: got %0d entries valid=%b want 8 valid=0", n, rd_valid); end
  endtask

  task automatic test_short_capture();
    int n;
    bit rr;
    logic [DW-1:0] v;
    v = $urandom(); trig_mask = '1; trig_value = v;
    tick(1, 0, '0, 0);
    for (int s = 0; s < 5; s++) begin
      if ($urandom % 2 == 1) tick(0, 0, mk(v), 0);
      tick(0, 1, mk(s == 2 ? v : (s < 2 ? v ^ ($urandom() | 32'h1) : $urandom())), 0);
      checks++;
      if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
        fails++; $display("FAIL short_flags s=%0d: got %b want %b", s, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
      end
    end
    n = 0;
    for (int c = 0; c < 60 && phase == 3; c++) begin
      rr = ($urandom % 4 != 0);
      checks++;
      if (rd_data !== expq[0] || (n == 2 && rd_data[DW-1:0] !== v)) begin
        fails++; $display("FAIL short_data n=%0d: got %h want %h", n, rd_data, expq[0]);
      end
      if (rr) n++;
      tick(0, 0, '0, rr);
      checks++;
      if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
        fails++; $display("FAIL short_rd_flags c=%0d: got %b want %b", c, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
      end
    end
    checks++;
    if (n != 5 || wrapped !== 1'b0 || phase == 3) begin
      fails++; $display("FAIL short_count: got %0d entries wrapped=%b want 5 wrapped=0", n, wrapped);
    end
  endtask

  task automatic test_backpressure();
    int n, stall;
    bit rr, prev_hs;
    logic [CW-1:0] prev;
    logic [DW-1:0] v;
    v = $urandom(); trig_mask = '1; trig_value = v;
    tick(1, 0, '0, 0);
    for (int s = 0; s < 13; s++) tick(0, 1, mk(s == 10 ? v : (s < 10 ? ~v : $urandom())), 0);
    n = 0; stall = 0; prev_hs = 1; prev = '0;
    for (int c = 0; c < 40 && phase == 3; c++) begin
      rr = !(n == 3 && stall < 3);
      if (!rr) stall++;
      checks++;
      if (rd_data !== expq[0]) begin fails++; $display("FAIL bp_data n=%0d: got %h want %h", n, rd_data, expq[0]); end
      if (!prev_hs) begin
        checks++;
        if (rd_data !== prev) begin fails++; $display("FAIL bp_stable n=%0d: got %h want %h", n, rd_data, prev); end
      end
      prev = rd_data; prev_hs = rr;
      if (rr) n++;
      tick(0, 0, '0, rr);
      checks++;
      if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
        fails++; $display("FAIL bp_flags c=%0d: got %b want %b", c, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
      end
    end
    checks++;
    if (n != 8 || stall != 3) begin fails++; $display("FAIL bp_count: got %0d entries %0d stalls want 8 and 3", n, stall); end
  endtask

  task automatic test_masked_trigger();
    logic [DW-1:0] seq [3];
    int n;
    seq[0] = 32'h10; seq[1] = 32'h21; seq[2] = 32'h34;
    trig_mask = 32'h0000000F; trig_value = 32'h4;
    tick(1, 0, '0, 0);
    for (int s = 0; s < 3; s++) begin
      tick(0, 1, mk(seq[s]), 0);
      checks++;
      if (triggered !== (s == 2) || triggered !== m_trig) begin
        fails++; $display("FAIL mask_trig s=%0d: got %b want %b", s, triggered, s == 2);
      end
    end
    tick(0, 1, mk($urandom()), 0);
    tick(0, 1, mk($urandom()), 0);
    n = 0;
    for (int c = 0; c < 20 && phase == 3; c++) begin
      checks++;
      if (rd_data !== expq[0] || (n < 3 && rd_data[DW-1:0] !== seq[n])) begin
        fails++; $display("FAIL mask_data n=%0d: got %h want %h", n, rd_data, expq[0]);
      end
      n++;
      tick(0, 0, '0, 1);
    end
    checks++;
    if (n != 5) begin fails++; $display("FAIL mask_count: got %0d want 5", n); end
  endtask

  task automatic test_rearm();
    int n;
    logic [DW-1:0] v;
    v = $urandom(); trig_mask = '1; trig_value = v;
    tick(1, 0, '0, 0);
    for (int s = 0; s < 5; s++) tick(0, 1, mk(s == 3 ? v : ~v), 0);
    tick(1, 1, mk(v), 0);
    checks++;
    if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== 6'b100000 || exp_flags() !== 6'b100000) begin
      fails++; $display("FAIL rearm_post: got %b want 100000", {armed, triggered, done, wrapped, rd_valid, rd_last});
    end
    for (int s = 0; s < 5; s++) tick(0, 1, mk(s == 2 ? v : ~v), 0);
    tick(0, 0, '0, 1);
    tick(1, 0, '0, 1);
    checks++;
    if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== 6'b100000) begin
      fails++; $display("FAIL rearm_done: got %b want 100000", {armed, triggered, done, wrapped, rd_valid, rd_last});
    end
    for (int s = 0; s < 4; s++) tick(0, 1, mk(s == 1 ? v : ~v), 0);
    n = 0;
    for (int c = 0; c < 20 && phase == 3; c++) begin
      checks++;
      if (rd_data !== expq[0]) begin fails++; $display("FAIL rearm_data n=%0d: got %h want %h", n, rd_data, expq[0]); end
      n++;
      tick(0, 0, '0, 1);
    end
    checks++;
    if (n != 4 || rd_valid !== 1'b0) begin fails++; $display("FAIL rearm_count: got %0d valid=%b want 4 valid=0", n, rd_valid); end
    tick(1, 0, '0, 0);
    for (int s = 0; s < 3; s++) tick(0, 1, mk(s == 0 ? v : $urandom()), 0);
    tick(0, 0, '0, 1);
    reset = 1'b0;
    tick(0, 0, '0, 1);
    checks++;
    if (rd_valid !== 1'b0 || {armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
      fails++; $display("FAIL reset_readout: got %b want %b", {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
    end
    reset = 1'b1;
    tick(0, 1, mk(v), 1);
    checks++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_stale: got valid=%b want 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    bit rr;
    for (int r = 0; r < 4; r++) begin
      trig_mask = 32'h7; trig_value = $urandom();
      tick(1, 1'($urandom % 2), mk($urandom()), 0);
      for (int c = 0; c < 80 && (phase == 1 || phase == 2); c++) begin
        tick(0, ($urandom % 4 != 0), mk(c >= 60 ? trig_value : $urandom()), 0);
        checks++;
        if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
          fails++; $display("FAIL b2b_cap_flags r=%0d c=%0d: got %b want %b", r, c, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
        end
      end
      for (int c = 0; c < 100 && phase == 3; c++) begin
        rr = ($urandom % 3 != 0);
        checks++;
        if (rd_data !== expq[0]) begin fails++; $display("FAIL b2b_data r=%0d c=%0d: got %h want %h", r, c, rd_data, expq[0]); end
        tick(0, 1'($urandom % 2), mk($urandom()), rr);
        checks++;
        if ({armed, triggered, done, wrapped, rd_valid, rd_last} !== exp_flags()) begin
          fails++; $display("FAIL b2b_rd_flags r=%0d c=%0d: got %b want %b", r, c, {armed, triggered, done, wrapped, rd_valid, rd_last}, exp_flags());
        end
      end
      checks++;
      if (phase != 0) begin fails++; $display("FAIL b2b_timeout r=%0d: model phase %0d want 0", r, phase); end
    end
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; sample_valid = 1'b0; rd_ready = 1'b0;
    sample_data = '0; trig_mask = '0; trig_value = '0;
    test_reset();
    test_wrap_capture();
    test_short_capture();
    test_backpressure();
    test_masked_trigger();
    test_rearm();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
